// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Words are loaded through a valid/ready handshake
// and leave one bit per enabled clock. A new word can be loaded on the last bit, so there is no gap.
`timescale 1ns/1ps
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_LVL  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             shift_en_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             dout_last_o
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_last;
  logic             load_fire;

  // Outputs come from registers only; load_ready alone also looks at shift_en.
  always_comb begin
    dout_valid_o = (state_q == StShift);
    is_last      = dout_valid_o && (cnt_q == LastCnt);
    dout_last_o  = is_last;
    if (dout_valid_o) begin
      dout_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end else begin
      dout_o = IDLE_LVL;
    end
    load_ready_o = (state_q == StIdle) || (is_last && shift_en_i);
    load_fire    = load_valid_i && load_ready_o;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_fire) begin
      shreg_d = din_i;
      cnt_d   = '0;
      state_d = StShift;
    end else if (state_q == StShift && shift_en_i) begin
      if (cnt_q == LastCnt) begin
        state_d = StIdle;
      end else begin
        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1) share stimulus
// and are checked each cycle against bit queues built from every accepted word.
`timescale 1ns/1ps
module tb_piso_serializer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] din_i;
  logic       load_valid_i;
  logic       shift_en_i;

  logic m_ready, m_dout, m_valid, m_last;
  logic l_ready, l_dout, l_valid, l_last;

  int n_tests = 0;
  int n_fail  = 0;

  // Each entry is {last, data}; the front entry is the bit the DUT must be showing now.
  logic [1:0] q_msb[$];
  logic [1:0] q_lsb[$];

  always #15 clk_i = ~clk_i;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_dut_msb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .din_i       (din_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(m_ready),
    .shift_en_i  (shift_en_i),
    .dout_o      (m_dout),
    .dout_valid_o(m_valid),
    .dout_last_o (m_last)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_dut_lsb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .din_i       (din_i),
    .load_valid_i(load_valid_i),
    .load_ready_o(l_ready),
    .shift_en_i  (shift_en_i),
    .dout_o      (l_dout),
    .dout_valid_o(l_valid),
    .dout_last_o (l_last)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: a word accepted while the transmitter is empty, or while it shows
  // its final bit with the enable high, is appended as four bits in transmit order.
  always @(posedge clk_i) begin
    bit acc;
    if (!rst_i) begin
      acc = load_valid_i &&
            (q_msb.size() == 0 || (q_msb.size() == 1 && shift_en_i));
      if (shift_en_i && q_msb.size() != 0) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          q_msb.push_back({(i == 3), din_i[3-i]});
          q_lsb.push_back({(i == 3), din_i[i]});
        end
      end
    end
  end

  always @(posedge rst_i) begin
    q_msb.delete();
    q_lsb.delete();
  end

  // Monitor: compares both DUTs against the queue fronts on every falling edge.
  always @(negedge clk_i) begin
    logic ev, er;
    ev = (q_msb.size() != 0);
    er = !ev || (q_msb.size() == 1 && shift_en_i);
    chk("msb_valid", m_valid, ev);
    chk("lsb_valid", l_valid, ev);
    chk("msb_dout",  m_dout,  ev ? q_msb[0][0] : 1'b0);
    chk("lsb_dout",  l_dout,  ev ? q_lsb[0][0] : 1'b1);
    chk("msb_last",  m_last,  ev ? q_msb[0][1] : 1'b0);
    chk("lsb_last",  l_last,  ev ? q_lsb[0][1] : 1'b0);
    chk("msb_ready", m_ready, er);
    chk("lsb_ready", l_ready, er);
  end

  task automatic cyc(input logic lv, input logic [3:0] d, input logic se);
    load_valid_i = lv;
    din_i        = d;
    shift_en_i   = se;
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    int ph;
    rst_i        = 1'b1;
    load_valid_i = 1'b1;
    din_i        = 4'hF;
    shift_en_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    // Single word, continuous enable
    cyc(1'b1, 4'b1011, 1'b1);
    repeat (6) cyc(1'b0, 4'h0, 1'b1);

    // Back-to-back words; the held request is ignored until the last bit
    cyc(1'b1, 4'hA, 1'b1);
    repeat (4) cyc(1'b1, 4'h5, 1'b1);
    repeat (6) cyc(1'b0, 4'h0, 1'b1);

    // Enable one clock in three
    cyc(1'b1, 4'b1001, 1'b1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 4'h0, (i % 3) == 2);

    // Request during a middle bit is ignored
    cyc(1'b1, 4'b0001, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'hF, 1'b1);
    repeat (4) cyc(1'b0, 4'h0, 1'b1);

    // Asynchronous reset in the middle of a word
    cyc(1'b1, 4'b1111, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_msb_valid", m_valid, 1'b0);
    chk("rst_lsb_valid", l_valid, 1'b0);
    chk("rst_msb_dout",  m_dout,  1'b0);
    chk("rst_lsb_dout",  l_dout,  1'b1);
    chk("rst_msb_last",  m_last,  1'b0);
    chk("rst_msb_ready", m_ready, 1'b1);
    #9 rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    cyc(1'b1, 4'b1100, 1'b1);
    repeat (5) cyc(1'b0, 4'h0, 1'b1);

    // Long idle stretch
    repeat (10) cyc(1'b0, 4'h0, 1'b0);

    // Random traffic with three enable regimes
    ph = 0;
    for (int i = 0; i < 600; i++) begin
      logic se;
      unique case ((i / 100) % 3)
        0:       se = 1'b1;
        1:       se = ($urandom_range(0, 99) < 65);
        default: se = (ph == 0);
      endcase
      ph = (ph == 2) ? 0 : ph + 1;
      cyc(($urandom_range(0, 99) < 55), 4'($urandom), se);
    end
    repeat (8) cyc(1'b0, 4'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
